// File: rtl/mst_fsm_if.sv
// Command, response and register-bus signals for mst_fsm.
// The master modport is the FSM's view; the slave modport is the view from the surrounding logic.
interface mst_fsm_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  if_req_vld;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_wr_en;
    logic                  if_rd_en;
    logic [DATA_WIDTH-1:0] if_wr_data;
    logic                  if_ack_vld;
    logic [DATA_WIDTH-1:0] if_rd_data;
    logic                  if_err;
    logic                  if_soft_rst;

    modport master (
        input  cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy,
               if_ack_vld, if_rd_data, if_err,
        output cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout,
               if_req_vld, if_addr, if_wr_en, if_rd_en, if_wr_data, if_soft_rst
    );

    modport slave (
        output cmd_vld, cmd_wr, cmd_addr, cmd_wdata, rsp_rdy,
               if_ack_vld, if_rd_data, if_err,
        input  cmd_rdy, rsp_vld, rsp_rdata, rsp_err, rsp_timeout,
               if_req_vld, if_addr, if_wr_en, if_rd_en, if_wr_data, if_soft_rst
    );
endinterface

// File: rtl/mst_fsm.sv
// Initiator FSM: one command at a time -> single-cycle register request -> ack -> response.
// Define MST_FSM_TIMEOUT_EN to add the WAIT timeout counter and the ABORT (soft reset) state.
module mst_fsm #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic      clk,
    input  logic      rst,
    mst_fsm_if.master bus
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mst_fsm: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        RESP = 3'd3
`ifdef MST_FSM_TIMEOUT_EN
        , ABORT = 3'd4
`endif
    } state_t;

    state_t                state, nxt;
    logic                  cmd_rdy_q, req_vld_q, rsp_vld_q;
    logic                  wr_en_q, rd_en_q, rsp_err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  accept, ack_in_wait, rsp_done;

    assign accept      = (state == IDLE) && bus.cmd_vld && cmd_rdy_q;
    assign ack_in_wait = (state == WAIT) && bus.if_ack_vld;
    assign rsp_done    = (state == RESP) && bus.rsp_rdy;

`ifdef MST_FSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             expired;
    logic             rsp_to_q, soft_rst_q;

    // wait_cnt holds the 1-based index of the current WAIT cycle; an ack on the last one still wins
    assign expired = (state == WAIT) && !bus.if_ack_vld && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            rsp_to_q   <= 1'b0;
            soft_rst_q <= 1'b0;
        end else begin
            if (state == REQ)
                wait_cnt <= CNT_W'(1);
            else if (state == WAIT && !bus.if_ack_vld && !expired)
                wait_cnt <= wait_cnt + CNT_W'(1);

            if (ack_in_wait)
                rsp_to_q <= 1'b0;
            else if (expired)
                rsp_to_q <= 1'b1;
            else if (rsp_done)
                rsp_to_q <= 1'b0;

            soft_rst_q <= (nxt == ABORT);
        end
    end

    assign bus.rsp_timeout = rsp_to_q;
    assign bus.if_soft_rst = soft_rst_q;
`else
    assign bus.rsp_timeout = 1'b0;
    assign bus.if_soft_rst = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = REQ;
            REQ:  nxt = WAIT;
            WAIT: begin
                if (bus.if_ack_vld) nxt = RESP;
`ifdef MST_FSM_TIMEOUT_EN
                else if (expired) nxt = ABORT;
`endif
            end
            RESP: if (bus.rsp_rdy) nxt = IDLE;
`ifdef MST_FSM_TIMEOUT_EN
            ABORT: nxt = RESP;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Strobes are registered copies of the next-state decode, so no input reaches an output combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_rdy_q <= 1'b0;
            req_vld_q <= 1'b0;
            rsp_vld_q <= 1'b0;
        end else begin
            state     <= nxt;
            cmd_rdy_q <= (nxt == IDLE);
            req_vld_q <= (nxt == REQ);
            rsp_vld_q <= (nxt == RESP);
        end
    end

    // Request fields double as the command latch: loaded on accept, held through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            wr_en_q <= bus.cmd_wr;
            rd_en_q <= !bus.cmd_wr;
        end else if (nxt != REQ && nxt != WAIT) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else if (ack_in_wait) begin
            rdata_q   <= wr_en_q ? '0 : bus.if_rd_data;
            rsp_err_q <= bus.if_err;
        end
`ifdef MST_FSM_TIMEOUT_EN
        else if (expired) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b1;
        end
`endif
        else if (rsp_done) begin
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end
    end

    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.rsp_vld    = rsp_vld_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.if_req_vld = req_vld_q;
    assign bus.if_addr    = addr_q;
    assign bus.if_wr_en   = wr_en_q;
    assign bus.if_rd_en   = rd_en_q;
    assign bus.if_wr_data = wdata_q;
endmodule

// File: doc/mst_fsm.md
Name: mst_fsm

Overview:
- Initiator-side FSM for the native register access interface: req_vld / wr_en / rd_en / ack_vld / rd_data / err.
- Accepts one command at a time from an upstream valid/ready command port and drives a single-cycle request to the register slave.
- Waits for ack_vld, captures read data and error, and returns a response on a valid/ready response port.
- Sits between the bus-protocol front-end (APB/AXI-lite bridges) and the generated register block.

Parameters:
- ADDR_WIDTH, 32, width of command and request address.
- DATA_WIDTH, 32, width of write and read data.
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (only used with the optional feature); legal range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_vld  in  1  upstream command valid.
- cmd_rdy  out  1  upstream command ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  response caused by timeout.
- if_req_vld  out  1  request strobe to slave.
- if_addr  out  ADDR_WIDTH  request address.
- if_wr_en  out  1  write enable.
- if_rd_en  out  1  read enable.
- if_wr_data  out  DATA_WIDTH  write data.
- if_ack_vld  in  1  slave acknowledge.
- if_rd_data  in  DATA_WIDTH  slave read data; valid with ack.
- if_err  in  1  slave error; valid with ack.
- if_soft_rst  out  1  slave abort / soft reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, all internal registers 0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- States: IDLE, REQ, WAIT, RESP, ABORT.
- IDLE:
  - cmd_rdy = 1.
  - On cmd_vld, latch cmd_wr, cmd_addr and cmd_wdata, then go to REQ.
- REQ (exactly 1 cycle):
  - if_req_vld = 1.
  - if_wr_en = latched wr; if_rd_en = !latched wr.
  - if_addr and if_wr_data come from the latches.
  - Next state is WAIT.
- Request field hold: if_addr, if_wr_en, if_rd_en and if_wr_data stay stable from REQ through the cycle ack is sampled; they return to 0 in RESP.
- Ack timing: the slave's earliest ack is 1 cycle after the req. An ack seen during REQ is ignored.
- WAIT:
  - On if_ack_vld, capture if_rd_data (forced to 0 for writes) and if_err, then go to RESP.
  - rsp_timeout = 0 for this path.
- RESP:
  - rsp_vld = 1, holding rsp_rdata, rsp_err and rsp_timeout stable.
  - Go to IDLE when rsp_rdy = 1; otherwise stay.
  - cmd_rdy = 0 until the state is back in IDLE.
  - Minimum command-to-command spacing is 4 cycles: IDLE, REQ, WAIT, RESP.
- ABORT (optional feature only):
  - 1 cycle with if_soft_rst = 1.
  - Response regs set to rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Next state is RESP.
- Acks in IDLE, RESP or ABORT are spurious and ignored; no state change.
- Reset mid-transaction: everything returns to reset values at once. No response is generated for the in-flight command.
- Illegal state encoding: go to IDLE.

Optional Feature:
- Macro: MST_FSM_TIMEOUT_EN.
- Defined:
  - A counter clears on REQ and increments each WAIT cycle; its width is the minimum that holds TIMEOUT_CYCLES.
  - When the counter equals TIMEOUT_CYCLES with no ack that cycle, go to ABORT.
  - An ack in the same cycle as the expiry wins: normal response, no abort.
- Not defined:
  - WAIT waits indefinitely.
  - if_soft_rst and rsp_timeout are tied to 0.
  - No counter or ABORT state is instantiated.

Test Plan:
- Write:
  - Stimulus: cmd_wr=1, addr=0x10, wdata=0xA5A5A5A5; ack 1 cycle after req, if_err=0.
  - Required: if_req_vld pulses for 1 cycle with wr_en=1; rsp_vld asserts the cycle after ack with rsp_err=0 and rsp_rdata=0.
- Read with delay:
  - Stimulus: cmd_wr=0, addr=0x24; ack 3 cycles after req with if_rd_data=0xDEADBEEF.
  - Required: rd_en=1 held through WAIT; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave error:
  - Stimulus: read; ack with if_err=1.
  - Required: rsp_err=1, rsp_timeout=0.
- Response backpressure:
  - Stimulus: rsp_rdy held low 5 cycles; a second cmd_vld held high.
  - Required: rsp fields stable; cmd_rdy=0 throughout; second command accepted only in the cycle after the rsp_rdy handshake.
- Timeout (MST_FSM_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - Stimulus: read, no ack.
  - Required: if_soft_rst pulses 1 cycle after the 8th WAIT cycle; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with ack on the expiry cycle: required normal response, no if_soft_rst.
- Reset mid-WAIT:
  - Stimulus: assert rst during WAIT.
  - Required: all outputs 0 immediately, state IDLE, cmd_rdy=1 after release, no response emitted.
